dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
- Data-memory responder serving load/store requests from the CPU datapath over a valid/ready request channel and a one-cycle response pulse.
- Supports word and byte stores (sw/sb) and word and byte loads (lw/lb/lbu), with byte-lane merge on store and lane extract plus extension on load.
- Configurable wait-state latency, so the datapath can be exercised against a multi-cycle memory.

Parameters:
- ADDR_W, 12, word-address bits; storage is 2^ADDR_W 32-bit words.
- LATENCY, 2, wait cycles from acceptance to memory commit; legal range 1..15.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 10 = word; 01/11 reserved.
- req_sign  in  1  load byte: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; byte store uses bits 7:0.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  request rejected (misaligned, out of range, or reserved size).

Behaviour:
- Reset (reset=0, async): state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0, all storage words zeroed. req_ready=1 from the first cycle after release.
- States:
  - IDLE: req_ready=1. On a cycle with req_valid&&req_ready, latch we/size/sign/addr/wdata, load counter=LATENCY, go to BUSY.
  - BUSY: req_ready=0; counter decrements each edge. At the edge where counter==1: commit the store or sample the load, set resp_valid/resp_rdata/resp_err, go to RESP.
  - RESP: resp_valid=1 for exactly this cycle. Next edge: clear resp_valid, return to IDLE.
- Timing: accept at edge E0; commit at edge E_LATENCY; resp_valid high in the cycle after E_LATENCY. Back-to-back period is LATENCY+2 cycles.
- No resp_ready: the requester must take the response in the strobe cycle. resp_rdata and resp_err hold their last value until the next response.
- Error checks, evaluated on latched fields:
  - word access with addr[1:0]!=0;
  - addr[31:ADDR_W+2]!=0;
  - req_size 01 or 11.
  - On error: no storage change, resp_err=1, resp_rdata=0, same latency as a normal request.
- Byte lanes (little-endian): lane = addr[1:0]; lane 0 = bits 7:0, lane 3 = bits 31:24.
  - Byte store: replaces only the selected lane of word addr[ADDR_W+1:2]; the other three bytes are unchanged.
  - Byte load: extracts the selected lane, then sign- or zero-extends per req_sign.
- Word load: returns the full word. Stores: resp_rdata=0, resp_err=0.
- req_valid asserted while BUSY or RESP is ignored; there is no queuing.
- Request inputs are sampled only at acceptance; changes afterwards have no effect.
- Reset mid-operation: if reset is asserted before the commit edge, the store is not committed and no resp_valid is produced. Storage is cleared regardless.

Decomposition:
- Package dm_pkg:
  - size codes SZ_BYTE=2'b00, SZ_WORD=2'b10;
  - state encoding S_IDLE, S_BUSY, S_RESP;
  - lane-index type (2 bits).
- Sub-module byte_lane_unit (combinational):
  - store path: inputs old word, wdata, lane, size; output merged word.
  - load path: inputs word, lane, size, sign; output extended result.
- FSM, counter, error checking and storage array stay in dm_responder.

Test Plan:
1. Release reset, then lw addr 0x0 accepted at E0 (LATENCY=2) -> resp_valid high only in the cycle after E2, rdata=0x00000000, err=0; req_ready low from E0 until return to IDLE.
2. sw 0x10 <- 0x12345678; sb 0x11 wdata 0x000000AB; lw 0x10 -> 0x1234AB78; lb sign=1 at 0x11 -> 0xFFFFFFAB; lbu at 0x11 -> 0x000000AB.
3. lbu at 0x13 after test 2 -> 0x00000012; lb sign=1 at 0x10 -> 0x00000078.
4. sw at 0x6 data 0xDEADBEEF -> resp_err=1, rdata=0; then lw 0x4 -> 0x00000000. req_size=01 -> err=1. Address 0x00010000 with ADDR_W=12 -> err=1.
5. Hold req_valid high continuously with sw 0x20 <- 0x1, then a different request -> exactly one acceptance per LATENCY+2 cycles; no acceptance while BUSY or RESP.
6. sw 0x30 <- 0xCAFEF00D accepted, reset driven to 0 one cycle later, then released -> no resp_valid pulse; lw 0x30 -> 0x00000000.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
package dm_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Responder control states
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_RESP = 2'b10
    } state_t;

    // Byte lane within a 32-bit word (little-endian)
    typedef logic [1:0] lane_t;

    // True for the size codes that have no defined access width
    function automatic logic size_reserved(input logic [1:0] size);
        return (size != SZ_BYTE) && (size != SZ_WORD);
    endfunction

endpackage

// File: rtl/dm_responder_byte_lane_unit.sv
// Byte-lane steering: merges a store byte into a word, extracts and extends a load byte.
import dm_pkg::*;

module byte_lane_unit (
    input  logic [31:0] st_old_word,
    input  logic [31:0] st_wdata,
    input  lane_t       st_lane,
    input  logic [1:0]  st_size,
    output logic [31:0] st_merged,
    input  logic [31:0] ld_word,
    input  lane_t       ld_lane,
    input  logic [1:0]  ld_size,
    input  logic        ld_sign,
    output logic [31:0] ld_result
);

    logic [31:0] merged_s;
    logic [7:0]  byte_s;
    logic [31:0] result_s;

    // Store path: byte stores replace one lane, word stores replace everything
    always_comb begin
        merged_s = st_old_word;
        if (st_size == SZ_BYTE) begin
            case (st_lane)
                2'd0:    merged_s[7:0]   = st_wdata[7:0];
                2'd1:    merged_s[15:8]  = st_wdata[7:0];
                2'd2:    merged_s[23:16] = st_wdata[7:0];
                2'd3:    merged_s[31:24] = st_wdata[7:0];
                default: merged_s        = st_old_word;
            endcase
        end else begin
            merged_s = st_wdata;
        end
    end

    // Load path: pick the addressed lane and extend it, or pass the whole word
    always_comb begin
        byte_s   = 8'h00;
        result_s = ld_word;
        case (ld_lane)
            2'd0:    byte_s = ld_word[7:0];
            2'd1:    byte_s = ld_word[15:8];
            2'd2:    byte_s = ld_word[23:16];
            2'd3:    byte_s = ld_word[31:24];
            default: byte_s = 8'h00;
        endcase
        if (ld_size == SZ_BYTE) begin
            result_s = {{24{ld_sign & byte_s[7]}}, byte_s};
        end else begin
            result_s = ld_word;
        end
    end

    assign st_merged = merged_s;
    assign ld_result = result_s;

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: one request at a time, fixed wait-state latency,
// word/byte stores with lane merge and word/byte loads with extension.
import dm_pkg::*;

module dm_responder #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] LAT_INIT = 4'(LATENCY);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  cnt_r;
    logic        we_r;
    logic [1:0]  size_r;
    logic        sign_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic        resp_valid_r;
    logic [31:0] resp_rdata_r;
    logic        resp_err_r;
    logic [31:0] mem_r [DEPTH];

    logic              accept_s;
    logic              commit_s;
    logic              err_s;
    logic [ADDR_W-1:0] word_idx_s;
    lane_t             lane_s;
    logic [31:0]       old_word_s;
    logic [31:0]       merged_s;
    logic [31:0]       ld_result_s;

    assign accept_s   = req_valid && (state_r == S_IDLE);
    assign commit_s   = (state_r == S_BUSY) && (cnt_r == 4'd1);
    assign word_idx_s = addr_r[ADDR_W+1:2];
    assign lane_s     = addr_r[1:0];
    assign old_word_s = mem_r[word_idx_s];

    // Rejections are judged on the latched request only
    assign err_s = size_reserved(size_r)
                || ((size_r == SZ_WORD) && (addr_r[1:0] != 2'b00))
                || (|addr_r[31:ADDR_W+2]);

    byte_lane_unit u_lanes (
        .st_old_word (old_word_s),
        .st_wdata    (wdata_r),
        .st_lane     (lane_s),
        .st_size     (size_r),
        .st_merged   (merged_s),
        .ld_word     (old_word_s),
        .ld_lane     (lane_s),
        .ld_size     (size_r),
        .ld_sign     (sign_r),
        .ld_result   (ld_result_s)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: accept in IDLE, wait out the latency, strobe once, return
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = S_BUSY;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_BUSY: begin
                if (commit_s) begin
                    state_nxt_s = S_RESP;
                end else begin
                    state_nxt_s = S_BUSY;
                end
            end
            S_RESP:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Request latch, wait counter and response registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r        <= 4'd0;
            we_r         <= 1'b0;
            size_r       <= 2'b00;
            sign_r       <= 1'b0;
            addr_r       <= 32'h0000_0000;
            wdata_r      <= 32'h0000_0000;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            resp_err_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                we_r    <= req_we;
                size_r  <= req_size;
                sign_r  <= req_sign;
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
                cnt_r   <= LAT_INIT;
            end else if (state_r == S_BUSY) begin
                cnt_r <= cnt_r - 4'd1;
            end else begin
                cnt_r <= cnt_r;
            end

            if (commit_s) begin
                resp_valid_r <= 1'b1;
                resp_err_r   <= err_s;
                if (err_s || we_r) begin
                    resp_rdata_r <= 32'h0000_0000;
                end else begin
                    resp_rdata_r <= ld_result_s;
                end
            end else if (state_r == S_RESP) begin
                resp_valid_r <= 1'b0;
            end else begin
                resp_valid_r <= resp_valid_r;
            end
        end
    end

    // Storage: cleared on reset, written only by a clean store at commit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (commit_s && we_r && !err_s) begin
            mem_r[word_idx_s] <= merged_s;
        end
    end

    assign req_ready  = (state_r == S_IDLE);
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder (ADDR_W=12, LATENCY=2).
module tb_dm_responder;

    localparam int LAT = 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] erd;
        logic        eer;
        string       nm;
    } req_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        string       nm;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    dm_responder #(.ADDR_W(12), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_sign   (req_sign),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits for IDLE, presents one request for one accepting edge, then scrambles inputs
    task automatic send(input req_t r, input bit push);
        int w;
        @(negedge clk);
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: req_ready stayed low, expected 1", r.nm);
        end
        req_valid = 1'b1;
        req_we    = r.we;
        req_size  = r.sz;
        req_sign  = r.sg;
        req_addr  = r.addr;
        req_wdata = r.wd;
        if (push) sb_q.push_back('{r.erd, r.eer, r.nm});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = ~r.we;
        req_size  = 2'b11;
        req_sign  = ~r.sg;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = $urandom;
    endtask

    // Bounded wait for the response strobe
    task automatic wait_resp(output bit found, output logic [31:0] rd, output logic er);
        found = 1'b0;
        rd    = 32'h0;
        er    = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                found = 1'b1;
                rd    = resp_rdata;
                er    = resp_err;
            end
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = 2'b10;
        req_sign  = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b expected 0", resp_valid);
        end
        n_cmp++;
        if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_resp: got rdata=%h err=%b expected 0/0", resp_rdata, resp_err);
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 1", req_ready);
        end
    endtask

    // First load: exact strobe cycle and ready window after acceptance
    task automatic test_lw_timing();
        req_t r;
        exp_t e;
        r = '{1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, "lw_0"};
        send(r, 1'b1);
        for (int i = 1; i <= LAT + 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (resp_valid !== (i == LAT + 1) || req_ready !== (i >= LAT + 2)) begin
                n_fail++;
                $display("FAIL lw_timing cycle %0d: got valid=%b ready=%b expected valid=%b ready=%b",
                         i, resp_valid, req_ready, (i == LAT + 1), (i >= LAT + 2));
            end
            if (i == LAT + 1) begin
                e = sb_q.pop_front();
                n_cmp++;
                if (resp_rdata !== e.rd || resp_err !== e.err) begin
                    n_fail++;
                    $display("FAIL %s: got rdata=%h err=%b expected rdata=%h err=%b",
                             e.nm, resp_rdata, resp_err, e.rd, e.err);
                end
            end
        end
    endtask

    task automatic test_store_load();
        req_t t[8];
        exp_t e;
        bit f;
        logic [31:0] rd;
        logic er;
        t[0] = '{1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, 32'h0, 1'b0, "sw_10"};
        t[1] = '{1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB, 32'h0, 1'b0, "sb_11"};
        t[2] = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1234_AB78, 1'b0, "lw_10"};
        t[3] = '{1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'hFFFF_FFAB, 1'b0, "lb_11"};
        t[4] = '{1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h0000_00AB, 1'b0, "lbu_11"};
        t[5] = '{1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h0000_0012, 1'b0, "lbu_13"};
        t[6] = '{1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 32'h0000_0078, 1'b0, "lb_10"};
        t[7] = '{1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h0000_0012, 1'b0, "lb_13"};
        foreach (t[k]) begin
            send(t[k], 1'b1);
            wait_resp(f, rd, er);
            e = sb_q.pop_front();
            n_cmp++;
            if (!f || rd !== e.rd || er !== e.err) begin
                n_fail++;
                $display("FAIL %s: got seen=%0d rdata=%h err=%b expected rdata=%h err=%b",
                         e.nm, f, rd, er, e.rd, e.err);
            end
        end
    endtask

    task automatic test_lanes();
        req_t t[5];
        exp_t e;
        bit f;
        logic [31:0] rd;
        logic er;
        t[0] = '{1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFF_FF80, 32'h0, 1'b0, "sb_12"};
        t[1] = '{1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 32'hFFFF_FF80, 1'b0, "lb_12"};
        t[2] = '{1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 32'h0000_0080, 1'b0, "lbu_12"};
        t[3] = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1280_AB78, 1'b0, "lw_10_b"};
        t[4] = '{1'b1, 2'b00, 1'b0, 32'h3FFF, 32'h0000_005A, 32'h0, 1'b0, "sb_top"};
        foreach (t[k]) begin
            send(t[k], 1'b1);
            wait_resp(f, rd, er);
            e = sb_q.pop_front();
            n_cmp++;
            if (!f || rd !== e.rd || er !== e.err) begin
                n_fail++;
                $display("FAIL %s: got seen=%0d rdata=%h err=%b expected rdata=%h err=%b",
                         e.nm, f, rd, er, e.rd, e.err);
            end
        end
    endtask

    task automatic test_errors();
        req_t t[9];
        exp_t e;
        bit f;
        logic [31:0] rd;
        logic er;
        t[0] = '{1'b1, 2'b10, 1'b0, 32'h6, 32'hDEAD_BEEF, 32'h0, 1'b1, "sw_mis"};
        t[1] = '{1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h0, 1'b0, "lw_4"};
        t[2] = '{1'b1, 2'b01, 1'b0, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b1, "sz01"};
        t[3] = '{1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, "sz11_ld"};
        t[4] = '{1'b0, 2'b10, 1'b0, 32'h0001_0000, 32'h0, 32'h0, 1'b1, "range_hi"};
        t[5] = '{1'b1, 2'b00, 1'b0, 32'h4000, 32'h0000_0077, 32'h0, 1'b1, "range_edge"};
        t[6] = '{1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, "no_alias"};
        t[7] = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1280_AB78, 1'b0, "lw_10_kept"};
        t[8] = '{1'b0, 2'b00, 1'b0, 32'h3FFF, 32'h0, 32'h0000_005A, 1'b0, "lbu_top"};
        foreach (t[k]) begin
            send(t[k], 1'b1);
            wait_resp(f, rd, er);
            e = sb_q.pop_front();
            n_cmp++;
            if (!f || rd !== e.rd || er !== e.err) begin
                n_fail++;
                $display("FAIL %s: got seen=%0d rdata=%h err=%b expected rdata=%h err=%b",
                         e.nm, f, rd, er, e.rd, e.err);
            end
        end
    endtask

    // req_valid held high: acceptances only every LAT+2 cycles
    task automatic test_back_to_back();
        int acc_idx[4];
        int n_acc;
        int n_resp;
        exp_t e;
        req_t t[2];
        bit f;
        logic [31:0] rd;
        logic er;
        n_acc  = 0;
        n_resp = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_sign  = 1'b0;
        req_addr  = 32'h20;
        req_wdata = 32'h1;
        for (int i = 0; i < 3 * (LAT + 2); i++) begin
            if (i > 0) @(negedge clk);
            if (i == 1) begin
                req_addr  = 32'h24;
                req_wdata = 32'h2;
            end
            if (resp_valid) begin
                n_resp++;
                e = sb_q.pop_front();
                n_cmp++;
                if (resp_rdata !== e.rd || resp_err !== e.err) begin
                    n_fail++;
                    $display("FAIL %s: got rdata=%h err=%b expected rdata=%h err=%b",
                             e.nm, resp_rdata, resp_err, e.rd, e.err);
                end
            end
            if (req_valid && req_ready) begin
                if (n_acc < 4) acc_idx[n_acc] = i;
                n_acc++;
                sb_q.push_back('{32'h0, 1'b0, "b2b_sw"});
            end
        end
        req_valid = 1'b0;
        n_cmp++;
        if (n_acc != 3 || n_resp != 3) begin
            n_fail++;
            $display("FAIL b2b_count: got accepts=%0d resps=%0d expected 3/3", n_acc, n_resp);
        end
        n_cmp++;
        if (n_acc >= 3 && (acc_idx[0] != 0 || acc_idx[1] != LAT + 2 || acc_idx[2] != 2 * (LAT + 2))) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d,%0d,%0d expected 0,%0d,%0d",
                     acc_idx[0], acc_idx[1], acc_idx[2], LAT + 2, 2 * (LAT + 2));
        end
        t[0] = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h1, 1'b0, "lw_20"};
        t[1] = '{1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 32'h2, 1'b0, "lw_24"};
        foreach (t[k]) begin
            send(t[k], 1'b1);
            wait_resp(f, rd, er);
            e = sb_q.pop_front();
            n_cmp++;
            if (!f || rd !== e.rd || er !== e.err) begin
                n_fail++;
                $display("FAIL %s: got seen=%0d rdata=%h err=%b expected rdata=%h err=%b",
                         e.nm, f, rd, er, e.rd, e.err);
            end
        end
    endtask

    // Reset before commit: no strobe, no store, storage cleared
    task automatic test_reset_midop();
        req_t r;
        req_t t[2];
        exp_t e;
        bit seen;
        bit f;
        logic [31:0] rd;
        logic er;
        seen = 1'b0;
        r = '{1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFE_F00D, 32'h0, 1'b0, "sw_30"};
        send(r, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        n_cmp++;
        if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_resp_clear: got rdata=%h err=%b expected 0/0", resp_rdata, resp_err);
        end
        reset = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_no_strobe: got strobe=%b expected 0", seen);
        end
        t[0] = '{1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h0, 1'b0, "lw_30"};
        t[1] = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, "lw_10_clr"};
        foreach (t[k]) begin
            send(t[k], 1'b1);
            wait_resp(f, rd, er);
            e = sb_q.pop_front();
            n_cmp++;
            if (!f || rd !== e.rd || er !== e.err) begin
                n_fail++;
                $display("FAIL %s: got seen=%0d rdata=%h err=%b expected rdata=%h err=%b",
                         e.nm, f, rd, er, e.rd, e.err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw_timing();
        test_store_load();
        test_lanes();
        test_errors();
        test_back_to_back();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
